// File: rtl/draw_scan_ctrl_if.sv
// Draw request / pixel stream bundle between a requester and draw_scan_ctrl.
// No storage; the interface itself adds no latency.
// No backpressure: the pixel side is a free-running strobe (plot) every cycle.
interface draw_scan_ctrl_if;
    logic        start;
    logic        clearMode;
    logic [3:0]  posSel;
    logic [1:0]  rowSel;
    logic [4:0]  spriteSel;
    logic [14:0] romAddr;
    logic [4:0]  memorySel;
    logic        black;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plot;
    logic        busy;
    logic        done;

    // Requester side: issues draw commands, observes the pixel stream.
    modport master (
        output start, clearMode, posSel, rowSel, spriteSel,
        input  romAddr, memorySel, black, x, y, plot, busy, done
    );

    // Controller side.
    modport slave (
        input  start, clearMode, posSel, rowSel, spriteSel,
        output romAddr, memorySel, black, x, y, plot, busy, done
    );
endinterface

// File: rtl/draw_scan_ctrl.sv
// Scans a sprite (or the whole screen in clear mode) column-major, one pixel per cycle.
// Latency: start edge 0 -> first address cycle 2 -> first plot cycle 3 -> done cycle N+3.
// No backpressure: plot streams N back-to-back cycles; start is ignored while busy.
module draw_scan_ctrl #(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           reset,
    draw_scan_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] SPR_W = 8'(SPRITE_W);
    localparam logic [6:0] SPR_H = 7'(SPRITE_H);
    localparam logic [7:0] SCR_W = 8'(SCREEN_W);
    localparam logic [6:0] SCR_H = 7'(SCREEN_H);

    state_t      state_q,    state_d;
    logic        clear_q,    clear_d;
    logic [4:0]  mem_sel_q,  mem_sel_d;
    logic [7:0]  x_org_q,    x_org_d;
    logic [6:0]  y_org_q,    y_org_d;
    logic [7:0]  x_off_q,    x_off_d;
    logic [6:0]  y_off_q,    y_off_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic [7:0]  x_q,        x_d;
    logic [6:0]  y_q,        y_d;
    logic        plot_q,     plot_d;

    logic [7:0]  reg_w;
    logic [6:0]  reg_h;
    logic        last_row;
    logic        last_col;

    // Sprite x-origin slots: a left bank stepping down by 6 and a right bank stepping up by 6.
    function automatic logic [7:0] x_origin(input logic [3:0] sel);
        logic [7:0] org;
        case (sel)
            4'd1:    org = 8'd36;
            4'd2:    org = 8'd30;
            4'd3:    org = 8'd24;
            4'd4:    org = 8'd18;
            4'd5:    org = 8'd12;
            4'd6:    org = 8'd6;
            4'd8:    org = 8'd90;
            4'd9:    org = 8'd96;
            4'd10:   org = 8'd102;
            4'd11:   org = 8'd108;
            4'd12:   org = 8'd114;
            4'd13:   org = 8'd120;
            default: org = 8'd0;
        endcase
        return org;
    endfunction

    function automatic logic [6:0] y_origin(input logic [1:0] sel);
        return (sel == 2'd1) ? 7'd30 : 7'd0;
    endfunction

    // Region size follows the mode latched for the current operation.
    assign reg_w    = clear_q ? SCR_W : SPR_W;
    assign reg_h    = clear_q ? SCR_H : SPR_H;
    assign last_row = (y_off_q == reg_h - 7'd1);
    assign last_col = (x_off_q == reg_w - 8'd1);

    // Next-state and datapath: offsets walk down a column, then step right.
    always_comb begin
        state_d    = state_q;
        clear_d    = clear_q;
        mem_sel_d  = mem_sel_q;
        x_org_d    = x_org_q;
        y_org_d    = y_org_q;
        x_off_d    = x_off_q;
        y_off_d    = y_off_q;
        rom_addr_d = rom_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        plot_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Command fields are captured on the accepting edge so that what
                // was presented alongside start is what gets drawn.
                if (bus.start) begin
                    state_d   = LOAD;
                    clear_d   = bus.clearMode;
                    mem_sel_d = bus.spriteSel;
                    x_org_d   = bus.clearMode ? 8'd0 : x_origin(bus.posSel);
                    y_org_d   = bus.clearMode ? 7'd0 : y_origin(bus.rowSel);
                end
            end
            LOAD: begin
                state_d    = SCAN;
                x_off_d    = 8'd0;
                y_off_d    = 7'd0;
                rom_addr_d = 15'd0;
            end
            SCAN: begin
                // The address presented now returns colour next cycle, so the
                // coordinates of this pixel are registered alongside plot.
                plot_d = 1'b1;
                x_d    = x_org_q + x_off_q;
                y_d    = y_org_q + y_off_q;
                if (last_row) begin
                    if (last_col) begin
                        state_d = FLUSH;
                    end else begin
                        y_off_d = 7'd0;
                        x_off_d = x_off_q + 8'd1;
                    end
                end else begin
                    y_off_d = y_off_q + 7'd1;
                end
                if (!(last_row && last_col)) begin
                    rom_addr_d = 15'(y_off_d) * 15'(reg_w) + 15'(x_off_d);
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clear_q    <= 1'b0;
            mem_sel_q  <= 5'd0;
            x_org_q    <= 8'd0;
            y_org_q    <= 7'd0;
            x_off_q    <= 8'd0;
            y_off_q    <= 7'd0;
            rom_addr_q <= 15'd0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            plot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clear_q    <= clear_d;
            mem_sel_q  <= mem_sel_d;
            x_org_q    <= x_org_d;
            y_org_q    <= y_org_d;
            x_off_q    <= x_off_d;
            y_off_q    <= y_off_d;
            rom_addr_q <= rom_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            plot_q     <= plot_d;
        end
    end

    assign bus.romAddr   = rom_addr_q;
    assign bus.memorySel = mem_sel_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.black     = clear_q && (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.plot      = plot_q;

endmodule

// File: tb/tb_draw_scan_ctrl.sv
// Directed bench for draw_scan_ctrl: sprite, clear, origin table, start/reset corner cases.
// Inputs are driven and outputs sampled on the falling edge; cycle k follows rising edge k.
// Every wait is bounded by a fixed cycle budget per operation.
module tb_draw_scan_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    draw_scan_ctrl_if bus ();

    draw_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written origin tables.
    int xo_tab [16] = '{0, 36, 30, 24, 18, 12, 6, 0, 90, 96, 102, 108, 114, 120, 0, 0};
    int yo_tab [4]  = '{0, 30, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: plain, 1: start pulse mid-scan, 2: reset at plot 500,
    // 3: start high across the DONE edge, 4: start raised in DONE and held.
    task automatic run_op(input logic clr, input logic [3:0] pos, input logic [1:0] row,
                          input logic [4:0] spr, input int mode);
        int n_exp, w, h, xo, yo;
        int plots, dones, done_cyc, first_cyc, last_cyc;
        int prev_addr, a39, a40, last_addr;
        int fx, fy, fa, sx, sy, sa, lx, ly;
        int blk_bad, busy_bad, msel_done;
        w     = clr ? 160 : 40;
        h     = clr ? 120 : 40;
        n_exp = w * h;
        xo    = clr ? 0 : xo_tab[pos];
        yo    = clr ? 0 : yo_tab[row];
        plots = 0; dones = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
        prev_addr = 0; a39 = 0; a40 = 0; last_addr = -1;
        fx = -1; fy = -1; fa = -1; sx = -1; sy = -1; sa = -1; lx = -1; ly = -1;
        blk_bad = 0; busy_bad = 0; msel_done = -1;

        @(negedge clk);
        bus.start = 1'b1; bus.clearMode = clr; bus.posSel = pos;
        bus.rowSel = row; bus.spriteSel = spr;

        for (int cyc = 1; cyc <= n_exp + 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // Scramble the command fields: they must already be latched.
                bus.start = 1'b0; bus.clearMode = ~clr; bus.posSel = ~pos;
                bus.rowSel = ~row; bus.spriteSel = ~spr;
            end
            if (cyc <= n_exp + 3) begin
                if (bus.busy !== 1'b1) busy_bad++;
                if (bus.black !== clr) blk_bad++;
            end
            if (bus.plot === 1'b1) begin
                plots++;
                if (plots == 1) begin fx = bus.x; fy = bus.y; fa = prev_addr; first_cyc = cyc; end
                if (plots == 2) begin sx = bus.x; sy = bus.y; sa = prev_addr; end
                if (plots == 40) a39 = prev_addr;
                if (plots == 41) a40 = prev_addr;
                lx = bus.x; ly = bus.y; last_addr = prev_addr; last_cyc = cyc;
            end
            if (bus.done === 1'b1) begin
                dones++; done_cyc = cyc; msel_done = bus.memorySel;
            end
            prev_addr = bus.romAddr;

            if (mode == 1 && cyc == 100) bus.start = 1'b1;
            if (mode == 1 && cyc == 101) bus.start = 1'b0;
            if (mode == 2 && plots == 500) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_plot", bus.plot, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_addr", bus.romAddr, 0);
                reset = 1'b0;
                return;
            end
            if (mode == 3 && cyc == n_exp + 2) bus.start = 1'b1;
            if (mode == 3 && cyc == n_exp + 3) bus.start = 1'b0;
            if (mode == 4 && cyc == n_exp + 3) bus.start = 1'b1;
            if (cyc == n_exp + 4) begin
                check("idle_busy", bus.busy, 0);
                check("idle_black", bus.black, 0);
                check("msel_hold", bus.memorySel, spr);
            end
            if (cyc == n_exp + 5) begin
                if (mode == 3) check("done_start_ignored", bus.busy, 0);
                if (mode == 4) begin
                    check("held_start_restart", bus.busy, 1);
                    bus.start = 1'b0;
                    pulse_reset();
                end
            end
        end

        check("busy_span", busy_bad, 0);
        check("black_level", blk_bad, 0);
        check("plot_count", plots, n_exp);
        check("first_cyc", first_cyc, 3);
        check("last_cyc", last_cyc, n_exp + 2);
        check("first_x", fx, xo);
        check("first_y", fy, yo);
        check("first_addr", fa, 0);
        check("last_x", lx, xo + w - 1);
        check("last_y", ly, yo + h - 1);
        check("last_addr", last_addr, n_exp - 1);
        check("done_cyc", done_cyc, n_exp + 3);
        check("done_pulses", dones, 1);
        check("msel_done", msel_done, spr);
        if (!clr) begin
            check("second_x", sx, xo);
            check("second_y", sy, yo + 1);
            check("second_addr", sa, 40);
            check("col_wrap_step", a40 - a39, 1 - 39 * 40);
        end
    endtask

    // Start a sprite draw, check the first plotted pixel, then abort with reset.
    task automatic probe(input logic [3:0] pos, input logic [1:0] row);
        @(negedge clk);
        bus.start = 1'b1; bus.clearMode = 1'b0; bus.posSel = pos;
        bus.rowSel = row; bus.spriteSel = 5'd0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("org_plot_%0d_%0d", pos, row), bus.plot, 1);
        check($sformatf("org_x_%0d_%0d", pos, row), bus.x, xo_tab[pos]);
        check($sformatf("org_y_%0d_%0d", pos, row), bus.y, yo_tab[row]);
        pulse_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.clearMode = 1'b0; bus.posSel = 4'd0;
        bus.rowSel = 2'd0; bus.spriteSel = 5'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_romAddr", bus.romAddr, 0);
        check("rst_memorySel", bus.memorySel, 0);
        check("rst_black", bus.black, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        check("rst_plot0", bus.plot, 0);
        check("rst_busy0", bus.busy, 0);
        check("rst_done0", bus.done, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 4'd1,  2'd1, 5'd10, 0);   // sprite at (36,30)
        run_op(1'b1, 4'd0,  2'd0, 5'd3,  0);   // full-screen clear
        run_op(1'b0, 4'd13, 2'd1, 5'd7,  1);   // start pulsed mid-scan
        run_op(1'b0, 4'd2,  2'd1, 5'd5,  2);   // reset at plot 500
        run_op(1'b0, 4'd2,  2'd1, 5'd5,  3);   // full draw after reset, start in DONE
        run_op(1'b0, 4'd8,  2'd0, 5'd1,  4);   // start held from DONE into IDLE

        for (int p = 0; p < 16; p++) begin
            for (int r = 0; r < 4; r++) begin
                probe(4'(p), 2'(r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
